// File: rtl/uart_tx_report.sv
// uart_tx_report: snapshots the parameter bytes and sends SYNC, params, CHK as back-to-back 8N1 frames.
module uart_tx_report #(
  parameter int BIT_CNT_MAX = 867,
  parameter int PAR_NUM = 5,
  parameter int PAR_WIDTH = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [PAR_NUM*PAR_WIDTH-1:0]  par_in,
  output logic                          tx_out,
  output logic                          busy,
  output logic                          done
);
  localparam int CW = BIT_CNT_MAX > 0 ? $clog2(BIT_CNT_MAX + 1) : 1;
  localparam int BW = $clog2(PAR_NUM + 2);
  localparam int SW = (PAR_NUM + 2) * 8;
  localparam logic [CW-1:0] CNT_MAX = CW'(BIT_CNT_MAX);
  localparam logic [BW-1:0] LAST_BYTE = BW'(PAR_NUM + 1);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [1:0] state;
  logic [CW-1:0] bit_cnt;
  logic [2:0] bit_idx;
  logic [BW-1:0] byte_idx;
  logic [SW-1:0] sh;
  logic [7:0] chk;
  logic bit_end;
  assign bit_end = bit_cnt == CNT_MAX;
  always_comb begin
    chk = '0;
    for (int i = 0; i < PAR_NUM; i++) chk = chk + par_in[i*PAR_WIDTH +: 8];
  end
  // The whole packet is loaded LSB-first into one shift register, so bytes leave in order SYNC..CHK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      sh <= '0;
      tx_out <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      bit_cnt <= (state == IDLE || bit_end) ? '0 : bit_cnt + 1'b1;
      case (state)
        IDLE: if (start) begin
          sh <= {chk, par_in, SYNC_BYTE};
          state <= START;
          tx_out <= 1'b0;
          busy <= 1'b1;
        end
        START: if (bit_end) begin
          state <= DATA;
          tx_out <= sh[0];
          sh <= sh >> 1;
        end
        DATA: if (bit_end) begin
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            state <= STOP;
            tx_out <= 1'b1;
          end else begin
            tx_out <= sh[0];
            sh <= sh >> 1;
          end
        end
        STOP: if (bit_end) begin
          if (byte_idx == LAST_BYTE) begin
            state <= IDLE;
            byte_idx <= '0;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            byte_idx <= byte_idx + 1'b1;
            state <= START;
            tx_out <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_report.sv
// tb_uart_tx_report: directed and random packets compared cycle by cycle against an expected line waveform.
module tb_uart_tx_report;
  localparam int BCM = 3;
  localparam int BT = BCM + 1;
  localparam int PKT = 10 * 7 * BT;
  logic clk = 0, rst = 1, start = 0;
  logic [39:0] par_in = '0;
  logic tx_out, busy, done;
  int passed = 0, total = 0;

  uart_tx_report #(.BIT_CNT_MAX(BCM)) dut (
    .clk(clk), .rst(rst), .start(start), .par_in(par_in),
    .tx_out(tx_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s {tx,busy,done} got=%b want=%b", tag, obs, exp);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  // Expected line: each byte framed as 0, data LSB first, 1; every bit held BT cycles.
  task automatic check_packet(input string tag, input logic [39:0] p, input int extra_start_at,
                              input bit change_par, input bit chain);
    logic [7:0] b [7];
    logic line [PKT];
    int sum = 0;
    b[0] = 8'hA5;
    for (int k = 0; k < 5; k++) begin
      b[k+1] = p[8*k +: 8];
      sum += p[8*k +: 8];
    end
    b[6] = 8'(sum % 256);
    for (int k = 0; k < 7; k++)
      for (int j = 0; j < 10; j++)
        for (int c = 0; c < BT; c++)
          line[(k*10 + j)*BT + c] = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[k][j-1];
    for (int c = 0; c < PKT; c++) begin
      check(tag, {tx_out, busy, done}, {line[c], 2'b10});
      start = (c == extra_start_at);
      if (c == 0 && change_par) par_in = {5{8'h55}};
      @(negedge clk);
    end
    check({tag, "_done"}, {tx_out, busy, done}, 3'b101);
    if (chain) begin
      start = 1;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [39:0] p, p2;
    repeat (3) @(negedge clk);
    rst = 0;
    for (int c = 0; c < 1000; c++) begin
      check("reset_idle", {tx_out, busy, done}, 3'b100);
      @(negedge clk);
    end
    p = {8'hFF, 8'h04, 8'h03, 8'h02, 8'h01};
    par_in = p;
    pulse_start();
    check_packet("nominal", p, -1, 0, 0);
    @(negedge clk);
    check("after_done", {tx_out, busy, done}, 3'b100);
    par_in = p;
    pulse_start();
    check_packet("snapshot", p, -1, 1, 0);
    par_in = p;
    pulse_start();
    check_packet("ignored_start", p, 20 * BT, 0, 0);
    @(negedge clk);
    check("ignored_idle", {tx_out, busy, done}, 3'b100);
    p = {$urandom, $urandom};
    p2 = {$urandom, $urandom};
    par_in = p;
    pulse_start();
    check_packet("b2b_first", p, -1, 0, 0);
    par_in = p2;
    start = 1;
    @(negedge clk);
    start = 0;
    check_packet("b2b_second", p2, -1, 0, 0);
    par_in = p;
    pulse_start();
    repeat (3 * 10 * BT + 2 * BT + 1) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("mid_reset", {tx_out, busy, done}, 3'b100);
    repeat (20) @(negedge clk);
    check("mid_reset_idle", {tx_out, busy, done}, 3'b100);
    for (int n = 0; n < 4; n++) begin
      p = {$urandom, $urandom};
      par_in = p;
      pulse_start();
      check_packet("random", p, (n == 1) ? $urandom_range(PKT - 1, 1) : -1, 0, 0);
      repeat ($urandom_range(3)) @(negedge clk);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
